// File: rtl/viterbi_stream_decoder.sv
// Streaming Viterbi decoder for log-domain HMMs.
// Forward add-compare-select over all states in one cycle per observation,
// psi-based backtrack at one step per cycle, then the decoded path is
// streamed out in forward time order on a valid/ready interface.
module viterbi_stream_decoder #(
    parameter int N = 64,
    parameter int I = 4,
    parameter int K = 4,
    parameter int W = 20,
    localparam int LW = $clog2(N + 1),
    localparam int SW = $clog2(I),
    localparam int OW = $clog2(K)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LW-1:0]     length,
    input  logic [I*I*W-1:0]  log_a,
    input  logic [I*W-1:0]    log_c,
    input  logic [I*K*W-1:0]  log_b,
    input  logic [OW-1:0]     obs_in,
    input  logic              obs_valid,
    output logic              obs_ready,
    output logic [SW-1:0]     path_out,
    output logic              path_valid,
    input  logic              path_ready,
    output logic              path_last,
    output logic [W-1:0]      score_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Time/step index width: indexes 0..N-1.
    localparam int TW = $clog2(N);
    localparam logic [LW-1:0] N_LEN = LW'(N);
    localparam logic [OW:0]   K_LIM = (OW + 1)'(K);
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, FWD, BEST, BACK, OUT} state_t;

    state_t              state;
    logic [TW-1:0]       len_m1;
    logic [TW-1:0]       t;
    logic [TW-1:0]       b;
    logic [TW-1:0]       o;
    logic [SW-1:0]       bt_s;

    logic signed [W-1:0] a_m [I][I];
    logic signed [W-1:0] c_m [I];
    logic signed [W-1:0] b_m [I][K];

    logic signed [W-1:0] delta     [I];
    logic signed [W-1:0] delta_nxt [I];
    logic [SW-1:0]       psi_nxt   [I];
    logic [SW-1:0]       psi       [N][I];
    logic [SW-1:0]       path_buf  [N];

    logic                obs_ok;
    logic [OW-1:0]       obs_sel;
    logic                obs_fire;
    logic signed [W-1:0] best_val;
    logic [SW-1:0]       best_idx;
    logic [SW-1:0]       bt_nxt;

    // Signed W-bit add that clamps instead of wrapping.
    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] x,
                                                    input logic signed [W-1:0] y);
        logic signed [W:0] s;
        s = {x[W-1], x} + {y[W-1], y};
        if (s[W] != s[W-1])
            sat_add = s[W] ? SMIN : SMAX;
        else
            sat_add = s[W-1:0];
    endfunction

    for (genvar gi = 0; gi < I; gi++) begin : g_unpack_i
        assign c_m[gi] = log_c[gi*W +: W];
        for (genvar gj = 0; gj < I; gj++) begin : g_unpack_a
            assign a_m[gi][gj] = log_a[(gi*I + gj)*W +: W];
        end
        for (genvar gk = 0; gk < K; gk++) begin : g_unpack_b
            assign b_m[gi][gk] = log_b[(gi*K + gk)*W +: W];
        end
    end

    // Out-of-range symbols are flagged; the table index is forced in range.
    assign obs_ok   = ({1'b0, obs_in} < K_LIM);
    assign obs_sel  = obs_ok ? obs_in : '0;
    assign obs_fire = obs_valid && obs_ready;

    // Add-compare-select for every destination state; strict '>' keeps the lowest index on ties.
    always_comb begin
        logic signed [W-1:0] m;
        logic signed [W-1:0] m_best;
        logic [SW-1:0]       arg;
        m      = '0;
        m_best = '0;
        arg    = '0;
        for (int j = 0; j < I; j++) begin
            m_best = sat_add(delta[0], a_m[0][j]);
            arg    = '0;
            for (int i = 1; i < I; i++) begin
                m = sat_add(delta[i], a_m[i][j]);
                if (m > m_best) begin
                    m_best = m;
                    arg    = SW'(i);
                end
            end
            if (t == '0)
                delta_nxt[j] = sat_add(c_m[j], b_m[j][obs_sel]);
            else
                delta_nxt[j] = sat_add(m_best, b_m[j][obs_sel]);
            psi_nxt[j] = arg;
        end
    end

    // Final-state selection over delta, lowest index on ties.
    always_comb begin
        best_val = delta[0];
        best_idx = '0;
        for (int i = 1; i < I; i++) begin
            if (delta[i] > best_val) begin
                best_val = delta[i];
                best_idx = SW'(i);
            end
        end
    end

    assign bt_nxt = psi[b][bt_s];

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_m1     <= '0;
            t          <= '0;
            b          <= '0;
            o          <= '0;
            bt_s       <= '0;
            obs_ready  <= 1'b0;
            path_out   <= '0;
            path_valid <= 1'b0;
            path_last  <= 1'b0;
            score_out  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0 && length <= N_LEN) begin
                            len_m1    <= TW'(length - LW'(1));
                            t         <= '0;
                            obs_ready <= 1'b1;
                            busy      <= 1'b1;
                            state     <= FWD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FWD: begin
                    if (obs_fire) begin
                        if (!obs_ok) begin
                            err       <= 1'b1;
                            obs_ready <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else if (t == len_m1) begin
                            obs_ready <= 1'b0;
                            state     <= BEST;
                        end else begin
                            t <= t + TW'(1);
                        end
                    end
                end
                BEST: begin
                    score_out <= best_val;
                    bt_s      <= best_idx;
                    b         <= len_m1;
                    o         <= '0;
                    if (len_m1 == '0) begin
                        path_out   <= best_idx;
                        path_valid <= 1'b1;
                        path_last  <= 1'b1;
                        state      <= OUT;
                    end else begin
                        state <= BACK;
                    end
                end
                BACK: begin
                    bt_s <= bt_nxt;
                    b    <= b - TW'(1);
                    if (b == TW'(1)) begin
                        path_out   <= bt_nxt;
                        path_valid <= 1'b1;
                        path_last  <= 1'b0;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (path_ready) begin
                        if (o == len_m1) begin
                            path_valid <= 1'b0;
                            path_last  <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            o         <= o + TW'(1);
                            path_out  <= path_buf[o + TW'(1)];
                            path_last <= ((o + TW'(1)) == len_m1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath storage: path metrics, survivor pointers and decoded path (no reset needed).
    always_ff @(posedge clk) begin
        if (state == FWD && obs_fire && obs_ok) begin
            for (int j = 0; j < I; j++) begin
                delta[j]  <= delta_nxt[j];
                psi[t][j] <= psi_nxt[j];
            end
        end
        if (state == BEST)
            path_buf[len_m1] <= best_idx;
        if (state == BACK)
            path_buf[b - TW'(1)] <= bt_nxt;
    end

endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// Self-checking bench: two decoder instances (W=20 and W=8) run the same
// control stream in lockstep; results are compared against a plain
// integer Viterbi reference computed inside the bench.
`timescale 1ns/1ps
module tb_viterbi_stream_decoder;

    localparam int N  = 8;
    localparam int I  = 3;
    localparam int K  = 3;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LW-1:0]     length;
    logic [I*I*20-1:0] log_a20;
    logic [I*20-1:0]   log_c20;
    logic [I*K*20-1:0] log_b20;
    logic [I*I*8-1:0]  log_a8;
    logic [I*8-1:0]    log_c8;
    logic [I*K*8-1:0]  log_b8;
    logic [1:0]        obs_in;
    logic              obs_valid;
    logic              path_ready;
    logic              obs_ready, obs_ready8;
    logic [1:0]        path_out, path_out8;
    logic              path_valid, path_valid8;
    logic              path_last, path_last8;
    logic [19:0]       score20;
    logic [7:0]        score8;
    logic              busy, busy8, done, done8, err, err8;

    viterbi_stream_decoder #(.N(N), .I(I), .K(K), .W(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .log_a(log_a20), .log_c(log_c20), .log_b(log_b20),
        .obs_in(obs_in), .obs_valid(obs_valid), .obs_ready(obs_ready),
        .path_out(path_out), .path_valid(path_valid), .path_ready(path_ready),
        .path_last(path_last), .score_out(score20), .busy(busy), .done(done), .err(err)
    );

    viterbi_stream_decoder #(.N(N), .I(I), .K(K), .W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .log_a(log_a8), .log_c(log_c8), .log_b(log_b8),
        .obs_in(obs_in), .obs_valid(obs_valid), .obs_ready(obs_ready8),
        .path_out(path_out8), .path_valid(path_valid8), .path_ready(path_ready),
        .path_last(path_last8), .score_out(score8), .busy(busy8), .done(done8), .err(err8)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    int ta  [2][I][I];
    int tc  [2][I];
    int tbm [2][I][K];
    int obs_v [N];
    int exp_path [2][N];
    int exp_score [2];
    int got20 [N];
    int got8  [N];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int satw(input longint x, input int wd);
        longint hi, lo;
        hi = (longint'(1) <<< (wd - 1)) - 1;
        lo = -(longint'(1) <<< (wd - 1));
        if (x > hi) return int'(hi);
        if (x < lo) return int'(lo);
        return int'(x);
    endfunction

    function automatic int rnd_val(input int wd, input bit full);
        int v;
        if (full) begin
            v = int'($urandom_range(0, (1 << wd) - 1));
            if (v >= (1 << (wd - 1))) v = v - (1 << wd);
        end else begin
            v = int'($urandom_range(0, 16)) - 12;
        end
        return v;
    endfunction

    // mode 0: reference tables, 1: all zero, 2: saturating, 3: random small, 4: random full-range
    task automatic set_tables(input int mode);
        for (int inst = 0; inst < 2; inst++) begin
            int wd;
            wd = (inst == 0) ? 20 : 8;
            for (int i = 0; i < I; i++) begin
                case (mode)
                    0: tc[inst][i] = -(i + 1);
                    1: tc[inst][i] = 0;
                    2: tc[inst][i] = -120;
                    default: tc[inst][i] = rnd_val(wd, mode == 4);
                endcase
                for (int j = 0; j < I; j++) begin
                    case (mode)
                        0: ta[inst][i][j] = (i == j) ? -1 : -4;
                        1, 2: ta[inst][i][j] = 0;
                        default: ta[inst][i][j] = rnd_val(wd, mode == 4);
                    endcase
                end
                for (int k = 0; k < K; k++) begin
                    case (mode)
                        0: tbm[inst][i][k] = (i == k) ? -1 : -5;
                        1: tbm[inst][i][k] = 0;
                        2: tbm[inst][i][k] = -100;
                        default: tbm[inst][i][k] = rnd_val(wd, mode == 4);
                    endcase
                end
            end
        end
        for (int i = 0; i < I; i++) begin
            log_c20[i*20 +: 20] = tc[0][i][19:0];
            log_c8[i*8 +: 8]    = tc[1][i][7:0];
            for (int j = 0; j < I; j++) begin
                log_a20[(i*I + j)*20 +: 20] = ta[0][i][j][19:0];
                log_a8[(i*I + j)*8 +: 8]    = ta[1][i][j][7:0];
            end
            for (int k = 0; k < K; k++) begin
                log_b20[(i*K + k)*20 +: 20] = tbm[0][i][k][19:0];
                log_b8[(i*K + k)*8 +: 8]    = tbm[1][i][k][7:0];
            end
        end
    endtask

    // Reference Viterbi with integer arithmetic, clamped to the instance width.
    task automatic model_run(input int L);
        int wd, bm, bi, m;
        int d [I];
        int nd [I];
        int ps [N][I];
        for (int inst = 0; inst < 2; inst++) begin
            wd = (inst == 0) ? 20 : 8;
            for (int i = 0; i < I; i++)
                d[i] = satw(longint'(tc[inst][i]) + tbm[inst][i][obs_v[0]], wd);
            for (int t = 1; t < L; t++) begin
                for (int j = 0; j < I; j++) begin
                    bm = 0;
                    bi = 0;
                    for (int i = 0; i < I; i++) begin
                        m = satw(longint'(d[i]) + ta[inst][i][j], wd);
                        if (i == 0 || m > bm) begin
                            bm = m;
                            bi = i;
                        end
                    end
                    nd[j] = satw(longint'(bm) + tbm[inst][j][obs_v[t]], wd);
                    ps[t][j] = bi;
                end
                for (int j = 0; j < I; j++) d[j] = nd[j];
            end
            bi = 0;
            for (int i = 1; i < I; i++) if (d[i] > d[bi]) bi = i;
            exp_score[inst] = d[bi];
            exp_path[inst][L-1] = bi;
            for (int t = L - 1; t >= 1; t--)
                exp_path[inst][t-1] = ps[t][exp_path[inst][t]];
        end
    endtask

    task automatic start_and_feed(input int L, input bit gaps, output int hs_cyc);
        int idx, guard;
        @(negedge clk);
        start  = 1'b1;
        length = L[LW-1:0];
        @(negedge clk);
        start = 1'b0;
        chk("obs_ready_rise", obs_ready, 1);
        chk("busy_fwd", busy, 1);
        idx = 0;
        guard = 0;
        hs_cyc = cyc;
        while (idx < L && guard < 500) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                obs_valid = 1'b0;
                obs_in    = 2'($urandom_range(0, 3));
            end else begin
                obs_valid = 1'b1;
                obs_in    = 2'(obs_v[idx]);
            end
            if (obs_valid && obs_ready) begin
                idx++;
                hs_cyc = cyc;
            end
            @(negedge clk);
            guard++;
        end
        obs_valid = 1'b0;
        if (idx < L) chk("obs_timeout", idx, L);
    endtask

    task automatic run_frame(input int L, input bit gaps, input bit bp);
        int hs_cyc, n, n8, guard, done_before;
        bit first, stalled;
        logic [1:0] prev_out;
        logic prev_last;
        model_run(L);
        done_before = done_cnt;
        start_and_feed(L, gaps, hs_cyc);
        n = 0; n8 = 0; guard = 0; first = 1'b1; stalled = 1'b0;
        prev_out = '0; prev_last = 1'b0;
        while (n < L && guard < 2000) begin
            if (path_valid && first) begin
                chk("latency", cyc - hs_cyc, L + 1);
                first = 1'b0;
            end
            if (stalled) begin
                chk("stall_valid", path_valid, 1);
                chk("stall_out", path_out, prev_out);
                chk("stall_last", path_last, prev_last);
            end
            path_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (path_valid && path_ready) begin
                got20[n] = int'(path_out);
                chk("path_last", path_last, (n == L - 1));
                n++;
            end
            if (path_valid8 && path_ready && n8 < N) begin
                got8[n8] = int'(path_out8);
                n8++;
            end
            stalled   = path_valid && !path_ready;
            prev_out  = path_out;
            prev_last = path_last;
            @(negedge clk);
            guard++;
        end
        path_ready = 1'b0;
        if (n < L) chk("path_timeout", n, L);
        chk("done_pulse", done, 1);
        chk("n8_count", n8, L);
        chk("score20", longint'($signed(score20)), exp_score[0]);
        chk("score8", longint'($signed(score8)), exp_score[1]);
        for (int t = 0; t < L; t++) begin
            chk("path20", got20[t], exp_path[0][t]);
            chk("path8", got8[t], exp_path[1][t]);
        end
        @(negedge clk);
        chk("done_once", done_cnt - done_before, 1);
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);
        chk("valid_idle", path_valid, 0);
    endtask

    task automatic bad_start(input int len);
        @(negedge clk);
        start  = 1'b1;
        length = len[LW-1:0];
        @(negedge clk);
        start = 1'b0;
        chk("err_bad_len", err, 1);
        chk("busy_bad_len", busy, 0);
        chk("ready_bad_len", obs_ready, 0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        chk("busy_stays_low", busy, 0);
    endtask

    initial begin
        int hs, pv, errs_before, dones_before;
        rst_n = 1'b0; start = 1'b0; length = '0; obs_valid = 1'b0;
        obs_in = '0; path_ready = 1'b0;
        set_tables(0);
        repeat (3) @(negedge clk);
        chk("rst_obs_ready", obs_ready, 0);
        chk("rst_path_valid", path_valid, 0);
        chk("rst_path_last", path_last, 0);
        chk("rst_path_out", path_out, 0);
        chk("rst_score", score20, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference tables, known path
        obs_v[0] = 0; obs_v[1] = 0; obs_v[2] = 1; obs_v[3] = 1; obs_v[4] = 2;
        run_frame(5, 1'b0, 1'b0);
        chk("ref_p0", got20[0], 0); chk("ref_p1", got20[1], 0); chk("ref_p2", got20[2], 1);
        chk("ref_p3", got20[3], 1); chk("ref_p4", got20[4], 2);
        chk("ref_score", longint'($signed(score20)), -16);
        // Same frame with stalls on both streams
        run_frame(5, 1'b1, 1'b1);
        chk("bp_p2", got20[2], 1); chk("bp_p4", got20[4], 2);

        // Single observation
        obs_v[0] = 2;
        run_frame(1, 1'b0, 1'b0);
        chk("l1_path", got20[0], 2);
        chk("l1_score", longint'($signed(score20)), -4);

        // All-zero tables: ties resolve to state 0
        set_tables(1);
        for (int t = 0; t < N; t++) obs_v[t] = int'($urandom_range(0, 2));
        run_frame(4, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) chk("tie_path", got20[t], 0);

        // Saturation in the narrow instance
        set_tables(2);
        run_frame(3, 1'b0, 1'b0);
        chk("sat_score8", longint'($signed(score8)), -128);

        // Rejected starts
        bad_start(0);
        bad_start(N + 1);

        // Invalid symbol mid-frame
        @(negedge clk);
        start = 1'b1; length = 4'd5;
        @(negedge clk);
        start = 1'b0; obs_valid = 1'b1; obs_in = 2'd1;
        @(negedge clk);
        obs_in = 2'd3;
        @(negedge clk);
        obs_valid = 1'b0;
        chk("err_obs", err, 1);
        chk("busy_obs_err", busy, 0);
        chk("ready_obs_err", obs_ready, 0);
        pv = 0;
        path_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            pv = pv + int'(path_valid);
        end
        path_ready = 1'b0;
        chk("no_path_after_err", pv, 0);

        // Reset during backtrack
        set_tables(3);
        for (int t = 0; t < N; t++) obs_v[t] = int'($urandom_range(0, 2));
        model_run(N);
        errs_before = err_cnt;
        dones_before = done_cnt;
        start_and_feed(N, 1'b0, hs);
        @(negedge clk);
        chk("best_score", longint'($signed(score20)), exp_score[0]);
        chk("busy_back", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_valid", path_valid, 0);
        chk("mr_last", path_last, 0);
        chk("mr_out", path_out, 0);
        chk("mr_ready", obs_ready, 0);
        chk("mr_score", score20, 0);
        chk("mr_done", done, 0);
        chk("mr_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_no_done", done_cnt - dones_before, 0);
        chk("mr_no_err", err_cnt - errs_before, 0);
        run_frame(N, 1'b0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            set_tables((f % 2 == 0) ? 3 : 4);
            for (int t = 0; t < N; t++) obs_v[t] = int'($urandom_range(0, 2));
            run_frame(int'($urandom_range(1, N)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
